// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: debounced single-step or timed auto-step, a
// synchronous-ROM wait, then IR latch and PC advance.
module inst_fetch_ctrl #(
  parameter int DEB_CYCLES = 20,
  parameter int ROM_LAT    = 1,
  parameter int ADDR_W     = 6,
  parameter int RUN_DIV    = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Step,
  input  logic              Run,
  input  logic [31:0]       Rom_data,
  output logic [ADDR_W-1:0] Rom_addr,
  output logic [31:0]       PC,
  output logic [31:0]       IR,
  output logic              IR_valid,
  output logic              Busy,
  output logic [15:0]       Fetch_cnt
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(RUN_DIV);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH} state_t;

  state_t            state;
  logic              sync1, sync2, deb;
  logic [DW-1:0]     deb_cnt;
  logic [RW-1:0]     div_cnt;
  logic [2:0]        wait_cnt;
  logic [ADDR_W-1:0] pc_word;
  logic              deb_done, press, tick, start;

  // The press pulse coincides with the edge that flips the debounced level,
  // so the fetch starts in the same cycle the new level is accepted.
  assign deb_done = (sync2 != deb) && (deb_cnt == DW'(DEB_CYCLES - 1));
  assign press    = deb_done && sync2;
  assign tick     = Run && (div_cnt == RW'(RUN_DIV - 1));
  assign start    = Run ? tick : press;

  assign Rom_addr = pc_word;
  assign PC       = {{(30 - ADDR_W){1'b0}}, pc_word, 2'b00};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= Step;
      sync2 <= sync1;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_done) begin
        deb     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst || !Run) div_cnt <= '0;
    else if (tick)   div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      pc_word   <= '0;
      IR        <= '0;
      IR_valid  <= 1'b0;
      Busy      <= 1'b0;
      Fetch_cnt <= '0;
    end else begin
      IR_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            Busy     <= 1'b1;
            wait_cnt <= 3'(ROM_LAT);
          end
        end
        FETCH: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == 3'd1) state <= LATCH;
        end
        LATCH: begin
          IR       <= Rom_data;
          IR_valid <= 1'b1;
          pc_word  <= pc_word + 1'b1;
          if (Fetch_cnt != 16'hFFFF) Fetch_cnt <= Fetch_cnt + 1'b1;
          Busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: main instance at DEB=4/ROM_LAT=1, a second
// at DEB=2/ROM_LAT=4 so a second press can complete debouncing while Busy.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, step, run, step_b, run_b;
  logic [31:0] rom_data, rom_data_b;
  logic [5:0]  rom_addr, rom_addr_b;
  logic [31:0] pc, ir, pc_b, ir_b;
  logic        ir_valid, busy, ir_valid_b, busy_b;
  logic [15:0] fetch_cnt, fetch_cnt_b;
  logic [31:0] rom_pipe [4];

  int n_chk = 0, n_err = 0;
  int n_vld = 0, n_vld_b = 0;

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.DEB_CYCLES(4), .ROM_LAT(1), .ADDR_W(6), .RUN_DIV(16)) u_dut (
    .Clk(clk), .Rst(rst), .Step(step), .Run(run), .Rom_data(rom_data),
    .Rom_addr(rom_addr), .PC(pc), .IR(ir), .IR_valid(ir_valid), .Busy(busy),
    .Fetch_cnt(fetch_cnt)
  );

  // Busy window is ROM_LAT+1 cycles; a debounced re-press needs 4, hence ROM_LAT=4.
  inst_fetch_ctrl #(.DEB_CYCLES(2), .ROM_LAT(4), .ADDR_W(6), .RUN_DIV(16)) u_dut_b (
    .Clk(clk), .Rst(rst), .Step(step_b), .Run(run_b), .Rom_data(rom_data_b),
    .Rom_addr(rom_addr_b), .PC(pc_b), .IR(ir_b), .IR_valid(ir_valid_b), .Busy(busy_b),
    .Fetch_cnt(fetch_cnt_b)
  );

  always @(posedge clk) begin
    rom_data    <= 32'hA500_0000 + 32'(rom_addr);
    rom_pipe[0] <= 32'hA500_0000 + 32'(rom_addr_b);
    rom_pipe[1] <= rom_pipe[0];
    rom_pipe[2] <= rom_pipe[1];
    rom_pipe[3] <= rom_pipe[2];
  end
  assign rom_data_b = rom_pipe[3];

  always @(negedge clk) begin
    if (ir_valid)   n_vld++;
    if (ir_valid_b) n_vld_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_release();
    step = 1'b1;
    repeat (8) tick();
    step = 1'b0;
    repeat (8) tick();
  endtask

  int v0, first, npos, seen;
  int pos [8];

  initial begin
    rst = 1'b1; step = 1'b0; run = 1'b0; step_b = 1'b0; run_b = 1'b0;
    repeat (3) tick();
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_vld", 32'(ir_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(fetch_cnt), 0);
    rst = 1'b0;
    tick();

    // Held press: one fetch, release does nothing
    v0 = n_vld;
    step = 1'b1;
    repeat (10) tick();
    step = 1'b0;
    repeat (12) tick();
    chk("t1_pulses", 32'(n_vld - v0), 1);
    chk("t1_ir", ir, 32'hA500_0000);
    chk("t1_pc", pc, 4);
    chk("t1_cnt", 32'(fetch_cnt), 1);

    // Bounce then hold: IR_valid at edge 8 counted from the final rise
    v0 = n_vld;
    step = 1'b1; tick();
    step = 1'b0; tick();
    step = 1'b1; tick();
    step = 1'b0; tick();
    step = 1'b1;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (ir_valid && first == 0) first = k;
    end
    repeat (4) tick();
    step = 1'b0;
    repeat (12) tick();
    chk("t2_latency", 32'(first), 8);
    chk("t2_pulses", 32'(n_vld - v0), 1);
    chk("t2_ir", ir, 32'hA500_0001);
    chk("t2_pc", pc, 8);

    // 64 presses from reset walk the whole ROM and wrap PC
    rst = 1'b1; tick(); rst = 1'b0; tick();
    v0 = n_vld;
    for (int i = 0; i < 64; i++) begin
      press_release();
      chk($sformatf("t3_ir%0d", i), ir, 32'hA500_0000 + 32'(i));
    end
    chk("t3_pc_wrap", pc, 0);
    chk("t3_cnt", 32'(fetch_cnt), 64);
    chk("t3_pulses", 32'(n_vld - v0), 64);

    // Run mode: ticks at edges 16+16k, IR at 18+16k; step presses ignored
    v0 = n_vld;
    run = 1'b1;
    npos = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 20) step = 1'b1;
      if (k == 40) step = 1'b0;
      if (ir_valid) begin
        if (npos < 8) pos[npos] = k;
        npos++;
      end
    end
    run = 1'b0;
    repeat (20) tick();
    chk("t4_npulse", 32'(npos), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t4_pos%0d", i), 32'(pos[i]), 32'(18 + 16 * i));
    chk("t4_total", 32'(n_vld - v0), 6);
    chk("t4_cnt", 32'(fetch_cnt), 70);
    chk("t4_pc", pc, 24);
    chk("t4_ir", ir, 32'hA500_0005);

    // Reset in the FETCH cycle aborts the fetch
    step = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy) begin
        seen = 1;
        break;
      end
    end
    chk("t5_busy_seen", 32'(seen), 1);
    rst = 1'b1; step = 1'b0;
    tick();
    chk("t5_pc", pc, 0);
    chk("t5_ir", ir, 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_vld", 32'(ir_valid), 0);
    rst = 1'b0;
    v0 = n_vld;
    repeat (15) tick();
    chk("t5_no_pulse", 32'(n_vld - v0), 0);
    press_release();
    chk("t5_ir_after", ir, 32'hA500_0000);
    chk("t5_pc_after", pc, 4);
    chk("t5_cnt_after", 32'(fetch_cnt), 1);

    // Second debounced press lands in FETCH and is dropped
    v0 = n_vld_b;
    step_b = 1'b1; repeat (2) tick();
    step_b = 1'b0; repeat (2) tick();
    step_b = 1'b1; repeat (12) tick();
    step_b = 1'b0; repeat (12) tick();
    chk("t6_pulses", 32'(n_vld_b - v0), 1);
    chk("t6_pc", pc_b, 4);
    chk("t6_cnt", 32'(fetch_cnt_b), 1);
    chk("t6_ir", ir_b, 32'hA500_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
